// File: rtl/fever_ctrl_pkg.sv
// +----------------------------------------------------------------------------+
// | fever_ctrl_pkg : shared slot-machine definitions (states, default sizes)   |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

package fever_ctrl_pkg;

  localparam int              DEF_SYM_W        = 4;
  localparam int              DEF_CNT_W        = 24;
  localparam logic [23:0]     DEF_FEVER_CYCLES = 24'd12_000_000;
  localparam int              NUM_REELS        = 3;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SPIN  = 2'd1,
    ST_JUDGE = 2'd2,
    ST_FEVER = 2'd3
  } state_e;

  function automatic logic reels_all_stopped(input logic [NUM_REELS-1:0] mask);
    return &mask;
  endfunction

endpackage

`default_nettype wire

// File: rtl/fever_ctrl_timer.sv
// +----------------------------------------------------------------------------+
// | fever_timer : loadable down-counter that saturates at zero                 |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

module fever_timer #(
  parameter int CNT_W = 24
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             load,
  input  logic [CNT_W-1:0] loadVal,
  output logic [CNT_W-1:0] count,
  output logic             active
);

  logic [CNT_W-1:0] count_q, count_d;
  logic             active_q, active_d;

  // active is kept as its own flop, equal to (count != 0) after every edge
  always_comb begin
    count_d  = count_q;
    active_d = active_q;
    if (load) begin
      count_d  = loadVal;
      active_d = (loadVal != '0);
    end else if (count_q != '0) begin
      count_d  = count_q - 1'b1;
      active_d = (count_q > {{(CNT_W-1){1'b0}}, 1'b1});
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      count_q  <= '0;
      active_q <= 1'b0;
    end else begin
      count_q  <= count_d;
      active_q <= active_d;
    end
  end

  assign count  = count_q;
  assign active = active_q;

endmodule

`default_nettype wire

// File: rtl/fever_ctrl.sv
// +----------------------------------------------------------------------------+
// | fever_ctrl : three-reel spin/stop sequencer with match judge and fever     |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

module fever_ctrl
  import fever_ctrl_pkg::*;
#(
  parameter int               SYM_W        = DEF_SYM_W,
  parameter int               CNT_W        = DEF_CNT_W,
  parameter logic [CNT_W-1:0] FEVER_CYCLES = DEF_FEVER_CYCLES
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             start,
  input  logic [2:0]       stop,
  input  logic [SYM_W-1:0] reel0,
  input  logic [SYM_W-1:0] reel1,
  input  logic [SYM_W-1:0] reel2,
  output logic             masterState,
  output logic             fever,
  output logic [2:0]       reelStopped,
  output logic [CNT_W-1:0] feverLeft,
  output logic             win
);

  state_e                   state_q, state_d;
  logic                     master_q, master_d;
  logic [2:0]               stopped_q, stopped_d;
  logic                     win_q, win_d;
  logic [2:0][SYM_W-1:0]    held_q, held_d;
  logic [2:0][SYM_W-1:0]    reel_vec;
  logic [2:0]               next_stopped;
  logic                     symbols_match;
  logic                     timer_load;
  logic [CNT_W-1:0]         timer_count;
  logic                     timer_active;

  assign reel_vec[0]   = reel0;
  assign reel_vec[1]   = reel1;
  assign reel_vec[2]   = reel2;
  assign next_stopped  = stopped_q | stop;
  assign symbols_match = (held_q[0] == held_q[1]) && (held_q[1] == held_q[2]);

  always_comb begin
    state_d    = state_q;
    master_d   = master_q;
    stopped_d  = stopped_q;
    held_d     = held_q;
    win_d      = 1'b0;
    timer_load = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d   = ST_SPIN;
          master_d  = 1'b1;
          stopped_d = 3'b000;
        end
      end

      ST_SPIN: begin
        // Only a reel that is still turning latches its symbol
        for (int i = 0; i < NUM_REELS; i++) begin
          if (stop[i] && !stopped_q[i]) begin
            held_d[i] = reel_vec[i];
          end
        end
        stopped_d = next_stopped;
        if (reels_all_stopped(next_stopped)) begin
          state_d  = ST_JUDGE;
          master_d = 1'b0;
        end
      end

      ST_JUDGE: begin
        if (symbols_match) begin
          state_d    = ST_FEVER;
          timer_load = 1'b1;
          win_d      = 1'b1;
        end else begin
          state_d = ST_IDLE;
        end
      end

      ST_FEVER: begin
        // Leave on the edge that takes the countdown from 1 to 0
        if (timer_count <= {{(CNT_W-1){1'b0}}, 1'b1}) begin
          state_d = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= ST_IDLE;
      master_q  <= 1'b0;
      stopped_q <= 3'b111;
      win_q     <= 1'b0;
      held_q    <= '0;
    end else begin
      state_q   <= state_d;
      master_q  <= master_d;
      stopped_q <= stopped_d;
      win_q     <= win_d;
      held_q    <= held_d;
    end
  end

  fever_timer #(
    .CNT_W (CNT_W)
  ) u_fever_timer (
    .clock   (clock),
    .reset_n (reset_n),
    .load    (timer_load),
    .loadVal (FEVER_CYCLES),
    .count   (timer_count),
    .active  (timer_active)
  );

  assign masterState = master_q;
  assign fever       = timer_active;
  assign reelStopped = stopped_q;
  assign feverLeft   = timer_count;
  assign win         = win_q;

endmodule

`default_nettype wire

// File: tb/tb_fever_ctrl.sv
// +----------------------------------------------------------------------------+
// | tb_fever_ctrl : randomized and directed bench with a behavioural model     |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_fever_ctrl;

  localparam int          SYM_W = 4;
  localparam int          CNT_W = 24;
  localparam int          FC    = 8;

  logic             clock = 1'b0;
  logic             reset_n;
  logic             start;
  logic [2:0]       stop;
  logic [SYM_W-1:0] reel0, reel1, reel2;
  logic             masterState;
  logic             fever;
  logic [2:0]       reelStopped;
  logic [CNT_W-1:0] feverLeft;
  logic             win;

  int n_checks = 0;
  int n_fail   = 0;

  // Behavioural model: plain flags and counters derived from the game rules
  bit       m_spinning;
  bit       m_judge_pending;
  bit       m_win;
  bit [2:0] m_stopped;
  int       m_left;
  int       m_held [3];

  fever_ctrl #(
    .SYM_W        (SYM_W),
    .CNT_W        (CNT_W),
    .FEVER_CYCLES (24'd8)
  ) dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .start       (start),
    .stop        (stop),
    .reel0       (reel0),
    .reel1       (reel1),
    .reel2       (reel2),
    .masterState (masterState),
    .fever       (fever),
    .reelStopped (reelStopped),
    .feverLeft   (feverLeft),
    .win         (win)
  );

  always #5 clock = ~clock;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_spinning      = 1'b0;
    m_judge_pending = 1'b0;
    m_win           = 1'b0;
    m_stopped       = 3'b111;
    m_left          = 0;
    for (int i = 0; i < 3; i++) m_held[i] = 0;
  endtask

  task automatic model_edge(input bit st, input bit [2:0] sp, input int r0, input int r1, input int r2);
    int reels [3];
    reels[0] = r0; reels[1] = r1; reels[2] = r2;
    m_win = 1'b0;
    if (m_judge_pending) begin
      m_judge_pending = 1'b0;
      if (m_held[0] == m_held[1] && m_held[1] == m_held[2]) begin
        m_left = FC;
        m_win  = 1'b1;
      end
    end else if (m_left > 0) begin
      m_left--;
    end else if (m_spinning) begin
      for (int i = 0; i < 3; i++) begin
        if (sp[i] && !m_stopped[i]) begin
          m_held[i]    = reels[i];
          m_stopped[i] = 1'b1;
        end
      end
      if (m_stopped == 3'b111) begin
        m_spinning      = 1'b0;
        m_judge_pending = 1'b1;
      end
    end else if (st) begin
      m_spinning = 1'b1;
      m_stopped  = 3'b000;
    end
  endtask

  task automatic compare_all();
    check_eq("masterState", masterState, m_spinning);
    check_eq("fever",       fever,       (m_left > 0));
    check_eq("reelStopped", reelStopped, m_stopped);
    check_eq("feverLeft",   feverLeft,   m_left);
    check_eq("win",         win,         m_win);
  endtask

  task automatic step(input bit st, input bit [2:0] sp, input int r0, input int r1, input int r2);
    start = st;
    stop  = sp;
    reel0 = r0[SYM_W-1:0];
    reel1 = r1[SYM_W-1:0];
    reel2 = r2[SYM_W-1:0];
    @(posedge clock);
    model_edge(st, sp, r0, r1, r2);
    #1;
    compare_all();
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step(1'b0, 3'b000, 0, 0, 0);
  endtask

  initial begin
    reset_n = 1'b0;
    start   = 1'b0;
    stop    = 3'b000;
    reel0   = '0;
    reel1   = '0;
    reel2   = '0;
    model_reset();
    repeat (2) @(posedge clock);
    @(negedge clock);
    compare_all();
    reset_n = 1'b1;

    // Matching spin, one reel at a time
    step(1'b1, 3'b000, 3, 3, 3);
    step(1'b0, 3'b001, 3, 3, 3);
    step(1'b0, 3'b010, 3, 3, 3);
    step(1'b0, 3'b100, 3, 3, 3);
    idle(FC + 4);

    // Non-matching spin
    step(1'b1, 3'b000, 3, 3, 5);
    step(1'b0, 3'b001, 3, 3, 5);
    step(1'b0, 3'b010, 3, 3, 5);
    step(1'b0, 3'b100, 3, 3, 5);
    idle(3);

    // All reels stopped together
    step(1'b1, 3'b000, 7, 7, 7);
    step(1'b0, 3'b111, 7, 7, 7);
    idle(FC + 3);

    // Repeated stop on reel 0 must not relatch
    step(1'b1, 3'b000, 0, 0, 0);
    step(1'b0, 3'b001, 2, 0, 0);
    step(1'b0, 3'b001, 9, 0, 0);
    step(1'b0, 3'b010, 9, 2, 0);
    step(1'b0, 3'b100, 9, 2, 2);
    idle(1);
    check_eq("repeat_stop_fever", fever, 1'b1);
    idle(FC + 1);

    // Start during fever is ignored; start right after fever falls is taken
    step(1'b1, 3'b000, 4, 4, 4);
    step(1'b0, 3'b111, 4, 4, 4);
    idle(3);
    step(1'b1, 3'b000, 0, 0, 0);
    step(1'b1, 3'b010, 0, 0, 0);
    for (int k = 0; k < 20 && m_left > 0; k++) step(1'b0, 3'b000, 0, 0, 0);
    step(1'b1, 3'b000, 0, 0, 0);
    check_eq("start_after_fever", masterState, 1'b1);
    step(1'b0, 3'b111, 1, 2, 3);
    idle(2);

    // Asynchronous reset mid-spin
    step(1'b1, 3'b000, 0, 0, 0);
    step(1'b0, 3'b010, 0, 5, 0);
    #2;
    reset_n = 1'b0;
    #1;
    model_reset();
    compare_all();
    @(negedge clock);
    reset_n = 1'b1;
    idle(2);

    // Random play
    for (int n = 0; n < 1500; n++) begin
      bit       st;
      bit [2:0] sp;
      st = ($urandom_range(0, 7) == 0);
      sp = ($urandom_range(0, 2) == 0) ? 3'($urandom_range(1, 7)) : 3'b000;
      step(st, sp, int'($urandom_range(0, 2)), int'($urandom_range(0, 2)), int'($urandom_range(0, 2)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
